soc_sysid_ext: RTL and testbench
================================

# soc_sysid_ext

Parametrised system-identification slave for the SOC Avalon-MM interconnect. It returns a build ID and build timestamp and, beyond those constants, provides a free-running uptime counter with coherent 64-bit readout, a read/write scratch register and a configurable bank of user constant words. It has registered read data with fixed read latency 1, and sits on the control bus next to the CPU's other peripheral slaves.

## Interface
Parameters:
- ID_VALUE, 32'h5482_9F9F: system ID word.
- TIMESTAMP, 32'h0: build timestamp word.
- ADDR_WIDTH, 4: word-address width.
- NUM_USER, 2: number of user constant words; must satisfy 6+NUM_USER <= 2**ADDR_WIDTH.
- USER_WORDS, {NUM_USER{32'h0}}: packed user constants; word k is bits [32k+31:32k].
- UPTIME_WIDTH, 64: uptime counter width, 33..64.

Ports:
- clock, in, 1: single clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- address, in, ADDR_WIDTH: word address.
- read, in, 1: read request.
- write, in, 1: write request.
- writedata, in, 32: write data.
- byteenable, in, 4: write byte lanes.
- readdata, out, 32: registered read data.
- readdatavalid, out, 1: one-cycle read-response strobe.

## Operation
Register map (word offsets):
- 0 ID: RO, ID_VALUE.
- 1 TIMESTAMP: RO, TIMESTAMP.
- 2 UPTIME_LO: RO, counter[31:0]. Reading it loads the snapshot register with counter[UPTIME_WIDTH-1:32], zero-extended to 32 bits.
- 3 UPTIME_HI: RO, snapshot register. It changes only on an UPTIME_LO read or on reset.
- 4 SCRATCH: RW, reset 0. Written per byteenable lane.
- 5 CONTROL: WO, reads return 0. Writing bit0=1 with byteenable[0]=1 clears the counter. Other bits are ignored.
- 6..6+NUM_USER-1 USER[k]: RO, USER_WORDS word k.
- All other offsets: read 0; writes ignored, no error response.

Behaviour:
- Uptime counter: +1 every clock, wraps from all-ones to 0. A clear write sets it to 0 on the next edge; increment resumes the cycle after that.
- Writes to RO offsets have no effect.
- Read and write in the same cycle are both performed. The read returns the pre-write value, e.g. SCRATCH returns its old contents.
- UPTIME_LO read in the same cycle as a clear returns the pre-clear count and snapshots the pre-clear high bits.
- There is no waitrequest; every request is accepted in the cycle it is presented.

## Timing
- Read latency is exactly 1. A read presented at edge N gives readdata and readdatavalid=1 after edge N+1, for one cycle.
- UPTIME_LO returns the counter value sampled at the accepting edge, i.e. the value present during the request cycle.
- readdata holds its last read value until the next read. readdatavalid is 0 on all non-read cycles.
- Back-to-back reads on consecutive cycles give consecutive readdatavalid pulses, with no bubble.
- Reset values: readdata=0, readdatavalid=0, counter=0, snapshot=0, SCRATCH=0.
- reset_n assertion mid-read suppresses the pending readdatavalid. Deassertion is assumed synchronised upstream, and the counter starts at 0 in the first cycle out of reset.

## Structure
- Package soc_sysid_pkg holds:
  - offset constants OFS_ID, OFS_TS, OFS_UP_LO, OFS_UP_HI, OFS_SCRATCH, OFS_CTRL, OFS_USER_BASE;
  - CTRL_CLR_BIT = 0.
- Sub-module soc_uptime_counter (parameter WIDTH) contains the counter, synchronous clear input, snapshot-load input and snapshot output.
- The top level contains address decode, SCRATCH, the read mux, and the readdata/readdatavalid registers.
- Elaboration-time check that 6+NUM_USER <= 2**ADDR_WIDTH and 33 <= UPTIME_WIDTH <= 64.

## Test plan
- Reset, then read offsets 0 and 1 -> 32'h54829F9F and TIMESTAMP, each with readdatavalid exactly one cycle after read. readdata=0 and readdatavalid=0 during reset.
- Write SCRATCH 32'hDEADBEEF with byteenable=4'b0101 onto 0 -> readback 32'h00AD00EF. A simultaneous read+write of SCRATCH returns the old value.
- Force the counter to 64'h0000_0001_FFFF_FFFF. Reading UPTIME_LO returns 32'hFFFF_FFFF, then UPTIME_HI returns 1, not 2, despite the carry.
- Write CONTROL=1 in the same cycle as an UPTIME_LO read -> the read returns the pre-clear count; the next UPTIME_LO read returns a small value equal to the elapsed cycles.
- NUM_USER=3, USER_WORDS={32'hC,32'hB,32'hA} -> offsets 6,7,8 return A,B,C. Offset 9 and offset 15 return 0. A write to offset 0 leaves the ID unchanged.
- Assert reset_n low for one cycle right after a read -> no readdatavalid pulse, and all state returns to its reset values.

Source files
------------

// File: rtl/soc_sysid_pkg.sv
// Shared register-map constants and helpers for the system-identification slave.
package soc_sysid_pkg;

    localparam logic [31:0] OFS_ID        = 32'd0;
    localparam logic [31:0] OFS_TS        = 32'd1;
    localparam logic [31:0] OFS_UP_LO     = 32'd2;
    localparam logic [31:0] OFS_UP_HI     = 32'd3;
    localparam logic [31:0] OFS_SCRATCH   = 32'd4;
    localparam logic [31:0] OFS_CTRL      = 32'd5;
    localparam logic [31:0] OFS_USER_BASE = 32'd6;

    localparam int unsigned CTRL_CLR_BIT  = 0;

    // Byte-lane merge of new data onto an existing word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-identification block.
interface soc_sysid_ext_if #(
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/soc_uptime_counter.sv
// Free-running uptime counter with synchronous clear and a high-word snapshot register.
module soc_uptime_counter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_snap_ld,
    output logic [WIDTH-1:0] o_count,
    output logic [31:0]      o_snap
);

    logic [WIDTH-1:0] r_count;
    logic [31:0]      r_snap;
    logic [31:0]      w_hi;

    always_comb begin
        w_hi = '0;
        w_hi[WIDTH-33:0] = r_count[WIDTH-1:32];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_snap  <= '0;
        end else begin
            r_count <= i_clr ? '0 : r_count + 1'b1;
            // Snapshot takes the pre-clear value when both happen together.
            if (i_snap_ld) r_snap <= w_hi;
        end
    end

    assign o_count = r_count;
    assign o_snap  = r_snap;

endmodule

// File: rtl/soc_sysid_ext.sv
// System-ID slave: constant words, uptime counter, scratch and user constants, read latency 1.
module soc_sysid_ext
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0]            ID_VALUE     = 32'h5482_9F9F,
    parameter logic [31:0]            TIMESTAMP    = 32'h0,
    parameter int unsigned            ADDR_WIDTH   = 4,
    parameter int unsigned            NUM_USER     = 2,
    parameter logic [32*NUM_USER-1:0] USER_WORDS   = '0,
    parameter int unsigned            UPTIME_WIDTH = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    soc_sysid_ext_if.slave bus
);

    if (6 + NUM_USER > 2 ** ADDR_WIDTH) begin : g_chk_map
        $error("soc_sysid_ext: register map does not fit the address space");
    end
    if (UPTIME_WIDTH < 33 || UPTIME_WIDTH > 64) begin : g_chk_up
        $error("soc_sysid_ext: UPTIME_WIDTH must be within 33..64");
    end

    logic [31:0]             w_ofs;
    logic                    w_snap_ld;
    logic                    w_clr;
    logic                    w_scr_we;
    logic [31:0]             w_rdata;
    logic [UPTIME_WIDTH-1:0] w_count;
    logic [31:0]             w_snap;

    logic [31:0] r_scratch;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    assign w_ofs     = 32'(bus.address);
    assign w_snap_ld = bus.read && (w_ofs == OFS_UP_LO);
    assign w_scr_we  = bus.write && (w_ofs == OFS_SCRATCH);
    assign w_clr     = bus.write && (w_ofs == OFS_CTRL) && bus.byteenable[0]
                       && bus.writedata[CTRL_CLR_BIT];

    soc_uptime_counter #(
        .WIDTH (UPTIME_WIDTH)
    ) u_uptime (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clr     (w_clr),
        .i_snap_ld (w_snap_ld),
        .o_count   (w_count),
        .o_snap    (w_snap)
    );

    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            OFS_ID:      w_rdata = ID_VALUE;
            OFS_TS:      w_rdata = TIMESTAMP;
            OFS_UP_LO:   w_rdata = w_count[31:0];
            OFS_UP_HI:   w_rdata = w_snap;
            OFS_SCRATCH: w_rdata = r_scratch;
            default: begin
                for (int k = 0; k < int'(NUM_USER); k++) begin
                    if (w_ofs == OFS_USER_BASE + 32'(k)) w_rdata = USER_WORDS[32*k +: 32];
                end
            end
        endcase
    end

    // Read data is captured from pre-write state, so read-during-write returns old contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rvalid <= bus.read;
            if (bus.read) r_rdata <= w_rdata;
            if (w_scr_we) r_scratch <= be_merge(r_scratch, bus.writedata, bus.byteenable);
        end
    end

    assign bus.readdata      = r_rdata;
    assign bus.readdatavalid = r_rvalid;

endmodule

// File: tb/tb_soc_sysid_ext.sv
// Directed plus randomized bench for soc_sysid_ext against a cycle-indexed register-map model.
module tb_soc_sysid_ext;

    localparam logic [31:0] ID_V  = 32'h5482_9F9F;
    localparam logic [31:0] TS_V  = 32'h2024_0611;
    localparam logic [95:0] USERS = {32'hC, 32'hB, 32'hA};

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    soc_sysid_ext_if #(.ADDR_WIDTH(4)) bus ();

    soc_sysid_ext #(
        .ID_VALUE     (ID_V),
        .TIMESTAMP    (TS_V),
        .ADDR_WIDTH   (4),
        .NUM_USER     (3),
        .USER_WORDS   (USERS),
        .UPTIME_WIDTH (64)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned base     = 0;
    logic [31:0] m_scratch = '0;
    logic [31:0] m_snap    = '0;
    logic [31:0] m_last    = '0;

    // Uptime value visible during cycle c is the number of cycles since reset release or clear.
    function automatic logic [63:0] cnt_at(input int unsigned c);
        return 64'(c - base);
    endfunction

    function automatic logic [31:0] m_rd(input logic [3:0] a, input int unsigned c);
        logic [63:0] cnt;
        cnt = cnt_at(c);
        case (a)
            4'd0:    return ID_V;
            4'd1:    return TS_V;
            4'd2:    return cnt[31:0];
            4'd3:    return m_snap;
            4'd4:    return m_scratch;
            4'd6:    return 32'hA;
            4'd7:    return 32'hB;
            4'd8:    return 32'hC;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle starting at a negedge; checks the response at the following negedge.
    task automatic access(input logic rd, input logic wr, input logic [3:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input string tag);
        int unsigned c;
        logic [31:0] exp;
        logic [63:0] cnt;
        c   = cyc;
        exp = m_rd(a, c);
        cnt = cnt_at(c);
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = a;
        bus.writedata  = wd;
        bus.byteenable = be;
        if (rd && a == 4'd2) m_snap = cnt[63:32];
        if (wr && a == 4'd4) begin
            for (int i = 0; i < 4; i++) if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
        end
        if (wr && a == 4'd5 && be[0] && wd[0]) base = c + 1;
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        if (rd) begin
            m_last = exp;
            chk({tag, "_valid"}, 32'(bus.readdatavalid), 32'd1);
            chk(tag, bus.readdata, exp);
        end else begin
            chk({tag, "_novalid"}, 32'(bus.readdatavalid), 32'd0);
            chk({tag, "_hold"}, bus.readdata, m_last);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;
        repeat (3) @(negedge clock);
        chk("rst_data", bus.readdata, 32'h0);
        chk("rst_valid", 32'(bus.readdatavalid), 32'd0);
        reset_n = 1'b1;
        base = cyc;

        access(1, 0, 4'd0, 0, 0, "id");
        access(1, 0, 4'd1, 0, 0, "ts");
        access(0, 0, 4'd0, 0, 0, "idle");
        access(1, 0, 4'd2, 0, 0, "up_lo");
        access(1, 0, 4'd3, 0, 0, "up_hi");

        access(0, 1, 4'd4, 32'hDEADBEEF, 4'b0101, "scr_wr");
        access(1, 0, 4'd4, 0, 0, "scr_be");
        access(1, 1, 4'd4, 32'h12345678, 4'b1111, "scr_rw_old");
        access(1, 0, 4'd4, 0, 0, "scr_new");

        access(0, 1, 4'd0, 32'hFFFFFFFF, 4'b1111, "id_wr");
        access(1, 0, 4'd0, 0, 0, "id_after_wr");
        access(1, 0, 4'd6, 0, 0, "user0");
        access(1, 0, 4'd7, 0, 0, "user1");
        access(1, 0, 4'd8, 0, 0, "user2");
        access(1, 0, 4'd9, 0, 0, "unmapped9");
        access(1, 0, 4'd15, 0, 0, "unmapped15");
        access(1, 0, 4'd5, 0, 0, "ctrl_rd");

        // Read of UPTIME_LO, clear, then the next read sees only the elapsed cycles.
        access(1, 0, 4'd2, 0, 0, "pre_clr");
        access(0, 1, 4'd5, 32'h1, 4'b0001, "clr_wr");
        access(0, 0, 4'd0, 0, 0, "clr_gap");
        access(1, 0, 4'd2, 0, 0, "post_clr");
        access(1, 1, 4'd2, 32'h1, 4'b1111, "ro_wr_up");
        access(0, 1, 4'd5, 32'h1, 4'b1110, "clr_be_off");
        access(1, 1, 4'd5, 32'h1, 4'b0001, "clr_rw");
        access(1, 0, 4'd2, 0, 0, "post_clr2");

        // Carry into the high word must not leak into the snapshot.
        force dut.u_uptime.r_count = 64'h0000_0001_FFFF_FFFF;
        bus.read = 1'b1; bus.address = 4'd2;
        @(negedge clock);
        release dut.u_uptime.r_count;
        bus.read = 1'b0;
        chk("force_lo_valid", 32'(bus.readdatavalid), 32'd1);
        chk("force_lo", bus.readdata, 32'hFFFF_FFFF);
        m_snap = 32'd1;
        m_last = 32'hFFFF_FFFF;
        access(1, 0, 4'd3, 0, 0, "force_hi");
        access(0, 1, 4'd4, 32'hA5A5A5A5, 4'b1111, "scr_set");

        // Reset during a read cycle suppresses its response and clears all state.
        bus.read = 1'b1; bus.address = 4'd4;
        #2 reset_n = 1'b0;
        @(negedge clock);
        bus.read = 1'b0;
        chk("rst_mid_valid", 32'(bus.readdatavalid), 32'd0);
        chk("rst_mid_data", bus.readdata, 32'h0);
        reset_n   = 1'b1;
        base      = cyc;
        m_scratch = '0;
        m_snap    = '0;
        m_last    = '0;
        access(1, 0, 4'd3, 0, 0, "rst_snap");
        access(1, 0, 4'd2, 0, 0, "rst_up");
        access(1, 0, 4'd4, 0, 0, "rst_scr");

        for (int n = 0; n < 60; n++) begin
            int unsigned op;
            logic [3:0]  a;
            op = $urandom_range(0, 3);
            a  = 4'($urandom_range(0, 15));
            access(op == 0 || op == 2, op == 1 || op == 2, a, $urandom, 4'($urandom), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
